fwd_hazard_ctrl: RTL
====================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Parametrised forwarding and hazard controller for the pipelined CPU.
//  Per ID/EX source operand, selects the youngest matching in-flight producer
//  among NUM_FWD forwarding stages. Also generates the load-use stall and
//  tracks one outstanding multi-cycle (MUL/DIV) result: countdown, done pulse,
//  and RAW stall. Sits between the pipeline registers and the EX operand muxes.
// PARAMETERS
//  ADDR_RFILE  5  register-file address width
//  NUM_SRC     2  source operands per instruction (rs, rt, ...)
//  NUM_FWD     2  forwarding stages; stage 1 = EX/MEM (youngest), stage NUM_FWD = oldest
//  MC_LAT      4  multi-cycle unit latency in cycles, >=2
//  SEL_W       $clog2(NUM_FWD+1)  width of one forward select (derived; do not override)
// PORTS
//  clk          in   1                   clock, rising edge
//  rst_n        in   1                   asynchronous active-low reset
//  id_valid     in   1                   instruction in ID/EX is valid
//  id_src_addr  in   NUM_SRC*ADDR_RFILE  source addresses; src s at [s*ADDR_RFILE +: ADDR_RFILE]
//  id_src_used  in   NUM_SRC             source s is actually read
//  ex_ld        in   1                   instruction one stage ahead is a load
//  ex_wb_addr   in   ADDR_RFILE          destination of that load
//  fwd_wr       in   NUM_FWD             stage k-1 writes the register file
//  fwd_addr     in   NUM_FWD*ADDR_RFILE  stage k-1 destination address
//  flush        in   1                   ID/EX instruction is squashed this cycle
//  mc_start     in   1                   issue a multi-cycle op this cycle
//  mc_addr      in   ADDR_RFILE          destination of the multi-cycle op
//  frd_sel      out  NUM_SRC*SEL_W       per source: 0 = register file, k = stage k
//  stall_id     out  1                   hold PC and IF/ID; insert a bubble
//  stall_q      out  1                   stall_id delayed one cycle (registered)
//  mc_busy      out  1                   multi-cycle op outstanding
//  mc_done      out  1                   one-cycle pulse: result available
//  mc_wb_addr   out  ADDR_RFILE          destination of the outstanding/finished op
// BEHAVIOUR
//  - Reset (rst_n=0, async): FSM=IDLE; stall_q=0, mc_busy=0, mc_done=0,
//    mc_wb_addr=0, counter=0. frd_sel and stall_id follow their combinational equations.
//  - Forward select (combinational, 0 latency). For source s with used=1 and addr!=0:
//    frd_sel = smallest k such that fwd_wr[k-1] && fwd_addr[k-1]==addr; else 0.
//    Address 0 is never forwarded. Unused sources give frd_sel=0.
//  - Stale-priority fix: if stall_q=1, stage 1 holds a bubble copy. Stage 1 is then
//    skipped in the match, and the next older match wins.
//  - Load-use: ld_haz = id_valid & ex_ld & ex_wb_addr!=0 & (any used src == ex_wb_addr).
//  - FSM states IDLE, MC_BUSY. Counter width is $clog2(MC_LAT).
//    IDLE, mc_start=1 -> MC_BUSY; count=MC_LAT-1; mc_wb_addr=mc_addr; mc_busy=1.
//    MC_BUSY, count>0 -> count-1.
//    MC_BUSY, count==0 -> IDLE; mc_busy=0; mc_done=1 for exactly one cycle;
//    mc_wb_addr holds its value.
//    mc_start while MC_BUSY is ignored; stall_id is already high in that case.
//  - mc_haz = mc_busy & id_valid & (mc_start | (mc_wb_addr!=0 & any used src == mc_wb_addr)).
//  - stall_id = ~flush & (ld_haz | mc_haz). stall_q <= stall_id every cycle.
//  - flush does not abort an outstanding multi-cycle op.
//  - Simultaneous mc_done and a new mc_start: the start is accepted in the next
//    cycle, from IDLE.
// CONFIGURATION
//  FWD_FLUSH_GATE_EN defined: while flush=1, all frd_sel are forced to 0 to save
//    operand-mux toggling.
//  FWD_FLUSH_GATE_EN undefined: frd_sel ignores flush. stall_id masking by flush applies in both builds.
// TESTING
//  1. fwd_wr=2'b11, fwd_addr={5'd3,5'd3}, src0=3 used -> frd_sel src0 = 1 (youngest wins).
//  2. fwd_wr=2'b10, fwd_addr[1]=7, src1=7 used -> frd_sel src1 = 2; src addr 0 -> sel 0.
//  3. ex_ld=1, ex_wb_addr=4, src0=4 used -> stall_id=1; next cycle stall_q=1 and stage-1 match skipped.
//  4. mc_start, mc_addr=9, MC_LAT=4 -> mc_busy for 4 cycles; mc_done pulses in cycle 4;
//     src=9 stalls throughout.
//  5. rst_n low mid MC_BUSY -> mc_busy, mc_done, stall_q = 0 immediately (async).
//  6. flush=1 with ld_haz -> stall_id=0; with FWD_FLUSH_GATE_EN, frd_sel=0.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//    Forwarding and hazard controller for the pipelined CPU. For each ID/EX
//    source operand it picks the youngest in-flight producer among NUM_FWD
//    forwarding stages. It also raises the load-use stall and tracks a single
//    outstanding multi-cycle (MUL/DIV) op: countdown, done pulse, RAW stall.
//
// Ports
//    clk, rst_n     clock (rising edge), asynchronous active-low reset
//    id_valid       ID/EX instruction is valid
//    id_src_addr    packed source addresses, src s at [s*ADDR_RFILE +: ADDR_RFILE]
//    id_src_used    per-source "actually read" flags
//    ex_ld          instruction one stage ahead is a load
//    ex_wb_addr     destination of that load
//    fwd_wr         per forwarding stage: stage writes the register file
//    fwd_addr       per forwarding stage destination, stage k at index k-1
//    flush          ID/EX instruction squashed this cycle
//    mc_start       issue a multi-cycle op
//    mc_addr        destination of the multi-cycle op
//    frd_sel        per source forward select: 0 = register file, k = stage k
//    stall_id       hold PC and IF/ID, insert a bubble
//    stall_q        stall_id delayed one cycle
//    mc_busy        multi-cycle op outstanding
//    mc_done        one-cycle pulse when the multi-cycle result is available
//    mc_wb_addr     destination of the outstanding / last finished op
//
// Build option
//    FWD_FLUSH_GATE_EN  when defined, all frd_sel are forced to 0 while flush=1.
//
// FSM states
//    state   | meaning
//    IDLE    | no multi-cycle op outstanding, mc_start accepted
//    MC_BUSY | op outstanding, counter runs down to 0, mc_start ignored

module fwd_hazard_ctrl #(
   parameter int ADDR_RFILE = 5,
   parameter int NUM_SRC    = 2,
   parameter int NUM_FWD    = 2,
   parameter int MC_LAT     = 4,
   parameter int SEL_W      = $clog2(NUM_FWD + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          id_valid,
   input  logic [NUM_SRC*ADDR_RFILE-1:0] id_src_addr,
   input  logic [NUM_SRC-1:0]            id_src_used,
   input  logic                          ex_ld,
   input  logic [ADDR_RFILE-1:0]         ex_wb_addr,
   input  logic [NUM_FWD-1:0]            fwd_wr,
   input  logic [NUM_FWD*ADDR_RFILE-1:0] fwd_addr,
   input  logic                          flush,
   input  logic                          mc_start,
   input  logic [ADDR_RFILE-1:0]         mc_addr,
   output logic [NUM_SRC*SEL_W-1:0]      frd_sel,
   output logic                          stall_id,
   output logic                          stall_q,
   output logic                          mc_busy,
   output logic                          mc_done,
   output logic [ADDR_RFILE-1:0]         mc_wb_addr
);

   localparam int CNT_W = $clog2(MC_LAT);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MC_BUSY = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;

   logic [ADDR_RFILE-1:0] src_a;
   logic [SEL_W-1:0]      sel;
   logic                  ld_match;
   logic                  mc_match;
   logic                  ld_haz;
   logic                  mc_haz;

   // Forward select and source-vs-destination compares.
   // Stages are scanned oldest to youngest so the youngest match is the last
   // assignment. While stall_q is set, stage 1 holds a bubble copy of the
   // stalled instruction's producer and must not win.
   always_comb begin
      frd_sel  = '0;
      src_a    = '0;
      sel      = '0;
      ld_match = 1'b0;
      mc_match = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         src_a = id_src_addr[s*ADDR_RFILE +: ADDR_RFILE];
         sel   = '0;
         if (id_src_used[s]) begin
            if (src_a == ex_wb_addr) ld_match = 1'b1;
            if (src_a == mc_wb_addr) mc_match = 1'b1;
            if (src_a != '0) begin
               for (int k = NUM_FWD; k >= 1; k--) begin
                  if (!(k == 1 && stall_q) && fwd_wr[k-1] &&
                      fwd_addr[(k-1)*ADDR_RFILE +: ADDR_RFILE] == src_a)
                     sel = SEL_W'(k);
               end
            end
         end
`ifdef FWD_FLUSH_GATE_EN
         if (flush) sel = '0;
`endif
         frd_sel[s*SEL_W +: SEL_W] = sel;
      end
   end

   assign ld_haz   = id_valid & ex_ld & (ex_wb_addr != '0) & ld_match;
   // A second mc_start while busy cannot be accepted, so it must stall too.
   assign mc_haz   = mc_busy & id_valid &
                     (mc_start | ((mc_wb_addr != '0) & mc_match));
   assign stall_id = ~flush & (ld_haz | mc_haz);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         mc_busy    <= 1'b0;
         mc_done    <= 1'b0;
         mc_wb_addr <= '0;
         stall_q    <= 1'b0;
      end else begin
         stall_q <= stall_id;
         mc_done <= 1'b0;
         case (state)
            IDLE: begin
               if (mc_start) begin
                  state      <= MC_BUSY;
                  count      <= CNT_INIT;
                  mc_wb_addr <= mc_addr;
                  mc_busy    <= 1'b1;
               end
            end
            MC_BUSY: begin
               if (count == '0) begin
                  state   <= IDLE;
                  mc_busy <= 1'b0;
                  mc_done <= 1'b1;
               end else begin
                  count <= count - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
